calibration_sweep_scheduler: RTL

Sequences repeated runs of the calibration trigger FSM. It sweeps the phase shift from `phase_start` to `phase_stop` in steps of `phase_step`, and fires `shots_per_step` starts at each phase. It sits between the slow-control register bank and the calibration trigger unit: it drives that unit's start and phase inputs and listens to its trigger-complete signal. It also supervises each shot with a timeout and supports abort.

---
 rtl/calib_pkg.sv | 22 ++
 rtl/edge_detect_2ff.sv | 22 ++
 rtl/calibration_sweep_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/calib_pkg.sv
// Shared types and default constants for the calibration sweep scheduler.
package calib_pkg;

    // Sweep sequencer states; the encoding is visible on scenario_state.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArm      = 3'd1,
        StWaitDone = 3'd2,
        StGap      = 3'd3,
        StNext     = 3'd4,
        StFinish   = 3'd5
    } sched_state_t;

    localparam int unsigned CAL_TIMEOUT    = 4_000_000;
    localparam int unsigned CAL_GAP_CYCLES = 1000;

    // States in which a sweep is actively running and may be aborted.
    function automatic logic sweep_active(sched_state_t s);
        return (s == StArm) || (s == StWaitDone) || (s == StGap) || (s == StNext);
    endfunction

endpackage

// File: rtl/edge_detect_2ff.sv
// Two-sample history on an (possibly asynchronous) input; flags the 0->1 pattern.
module edge_detect_2ff (
    input  logic clock,
    input  logic reset_signal,
    input  logic din,
    output logic rise
);

    logic [1:0] hist_q;

    // Newest sample enters at bit 0, oldest sits at bit 1.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], din};
        end
    end

    assign rise = (hist_q == 2'b01);

endmodule

// File: rtl/calibration_sweep_scheduler.sv
// Sweeps the trigger-unit phase from start to stop, firing a fixed number of
// shots per phase, with per-shot timeout supervision and abort.
module calibration_sweep_scheduler
    import calib_pkg::*;
#(
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned SHOTS_W    = 8,
    parameter int unsigned TIMEOUT    = CAL_TIMEOUT,
    parameter int unsigned GAP_CYCLES = CAL_GAP_CYCLES
) (
    input  logic               clock,
    input  logic               reset_signal,
    input  logic               run,
    input  logic               abort,
    input  logic               trig_done,
    input  logic [PHASE_W-1:0] phase_start,
    input  logic [PHASE_W-1:0] phase_step,
    input  logic [PHASE_W-1:0] phase_stop,
    input  logic [SHOTS_W-1:0] shots_per_step,
    output logic               unit_start,
    output logic [PHASE_W-1:0] phase_shift,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic               aborted,
    output logic [PHASE_W-1:0] step_index,
    output logic [SHOTS_W-1:0] shot_index,
    output logic [2:0]         scenario_state
);

    // One counter serves both the shot timeout and the inter-shot gap.
    localparam int unsigned CntMax = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic run_ev, abort_ev, trig_ev;

    edge_detect_2ff u_run_edge (
        .clock        (clock),
        .reset_signal (reset_signal),
        .din          (run),
        .rise         (run_ev)
    );

    edge_detect_2ff u_abort_edge (
        .clock        (clock),
        .reset_signal (reset_signal),
        .din          (abort),
        .rise         (abort_ev)
    );

    edge_detect_2ff u_trig_edge (
        .clock        (clock),
        .reset_signal (reset_signal),
        .din          (trig_done),
        .rise         (trig_ev)
    );

    sched_state_t       state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] step_idx_q;
    logic [SHOTS_W-1:0] shot_idx_q;
    logic               terr_q;
    logic               abrt_q;
    logic [CntW-1:0]    timer_q;
    // Shadow config. The start phase needs no shadow of its own: it is copied
    // straight into phase_q when the sweep is accepted.
    logic [PHASE_W-1:0] cfg_step_q;
    logic [PHASE_W-1:0] cfg_stop_q;
    logic [SHOTS_W-1:0] cfg_shots_q;

    logic [PHASE_W:0]   phase_nxt;
    logic [SHOTS_W:0]   shot_inc;
    logic               more_shots;
    logic               phase_done;
    logic               timeout_hit;
    logic               gap_last;

    // Next-phase arithmetic carries one extra bit so overflow ends the sweep
    // instead of wrapping back to a low phase.
    always_comb begin
        phase_nxt   = {1'b0, phase_q} + {1'b0, cfg_step_q};
        shot_inc    = {1'b0, shot_idx_q} + (SHOTS_W + 1)'(1);
        more_shots  = shot_inc < {1'b0, cfg_shots_q};
        phase_done  = phase_nxt[PHASE_W] || (cfg_step_q == '0) ||
                      (phase_nxt[PHASE_W-1:0] > cfg_stop_q);
        timeout_hit = (timer_q == CntW'(TIMEOUT - 1));
        gap_last    = (GAP_CYCLES == 0) || (timer_q == CntW'(GAP_CYCLES - 1));
    end

    // Sweep sequencer: state, phase, indices, sticky flags and shadow config.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            step_idx_q  <= '0;
            shot_idx_q  <= '0;
            terr_q      <= 1'b0;
            abrt_q      <= 1'b0;
            timer_q     <= '0;
            cfg_step_q  <= '0;
            cfg_stop_q  <= '0;
            cfg_shots_q <= '0;
        end else if (abort_ev && sweep_active(state_q)) begin
            // Abort outranks trig_done and timeout landing in the same cycle.
            abrt_q  <= 1'b1;
            state_q <= StFinish;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run_ev) begin
                        cfg_step_q  <= phase_step;
                        cfg_stop_q  <= phase_stop;
                        cfg_shots_q <= shots_per_step;
                        terr_q      <= 1'b0;
                        abrt_q      <= 1'b0;
                        step_idx_q  <= '0;
                        shot_idx_q  <= '0;
                        if ((shots_per_step == '0) || (phase_start > phase_stop)) begin
                            state_q <= StFinish;
                        end else begin
                            phase_q <= phase_start;
                            state_q <= StArm;
                        end
                    end
                end
                StArm: begin
                    timer_q <= '0;
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (trig_ev) begin
                        timer_q <= '0;
                        state_q <= StGap;
                    end else if (timeout_hit) begin
                        terr_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        timer_q <= timer_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (gap_last) begin
                        state_q <= StNext;
                    end else begin
                        timer_q <= timer_q + CntW'(1);
                    end
                end
                StNext: begin
                    if (more_shots) begin
                        shot_idx_q <= shot_inc[SHOTS_W-1:0];
                        state_q    <= StArm;
                    end else if (phase_done) begin
                        state_q <= StFinish;
                    end else begin
                        phase_q    <= phase_nxt[PHASE_W-1:0];
                        shot_idx_q <= '0;
                        step_idx_q <= step_idx_q + PHASE_W'(1);
                        state_q    <= StArm;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Strobes and status decode purely from the registered state.
    assign unit_start     = (state_q == StArm);
    assign done           = (state_q == StFinish);
    assign busy           = (state_q != StIdle) && (state_q != StFinish);
    assign scenario_state = state_q;
    assign phase_shift    = phase_q;
    assign step_index     = step_idx_q;
    assign shot_index     = shot_idx_q;
    assign timeout_err    = terr_q;
    assign aborted        = abrt_q;

endmodule
